// File: rtl/intmul_rr_sched_if.sv
// intmul_rr_sched_if: requester, multiplier and response signals of the shared-multiplier scheduler.
`ifndef WORD_SIZE
`define WORD_SIZE 64
`endif
interface intmul_rr_sched_if #(
    parameter int LOGQ    = `WORD_SIZE,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    logic                    en;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*LOGQ-1:0] req_a;
    logic [NUM_REQ*LOGQ-1:0] req_b;
    logic [LOGQ-1:0]         mul_a;
    logic [LOGQ-1:0]         mul_b;
    logic [2*LOGQ-1:0]       mul_c;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [2*LOGQ-1:0]       rsp_c;
    logic                    busy;
    modport master (
        output en, req_valid, req_a, req_b, mul_c,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, busy
    );
    modport slave (
        input  en, req_valid, req_a, req_b, mul_c,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, busy
    );
endinterface

// File: rtl/intmul_rr_sched.sv
// intmul_rr_sched: round-robin sharing of one pipelined multiplier between NUM_REQ requesters.
// Optional INTMUL_RR_SCHED_PRIO0_EN gives requester 0 strict priority without moving the pointer.
`ifndef WORD_SIZE
`define WORD_SIZE 64
`endif
module intmul_rr_sched #(
    parameter int LOGQ    = `WORD_SIZE,
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input logic clk,
    input logic rst,
    intmul_rr_sched_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               gnt;
    logic [NUM_REQ-1:0] vmask;
    logic [LOGQ-1:0]    ma, mb;
    logic [MUL_LAT:0]   tv;
    logic [ID_W-1:0]    tid [MUL_LAT];
    logic [ID_W-1:0]    rid;
    always_comb begin
`ifdef INTMUL_RR_SCHED_PRIO0_EN
        vmask = bus.req_valid & ~NUM_REQ'(1);
`else
        vmask = bus.req_valid;
`endif
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            cand = ID_W'((int'(ptr) + o) % NUM_REQ);
            if (!found && vmask[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`ifdef INTMUL_RR_SCHED_PRIO0_EN
        if (bus.req_valid[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        gnt = found & bus.en;
    end
    assign bus.req_ready = gnt ? NUM_REQ'(1) << win : '0;
    assign bus.mul_a     = ma;
    assign bus.mul_b     = mb;
    assign bus.rsp_valid = tv[MUL_LAT];
    assign bus.rsp_id    = rid;
    assign bus.rsp_c     = bus.mul_c;
    assign bus.busy      = |tv;
    // ids shift unconditionally; the output id only updates on a valid slot so it holds between responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= ID_W'(NUM_REQ - 1);
            ma  <= '0;
            mb  <= '0;
            tv  <= '0;
            tid <= '{default: '0};
            rid <= '0;
        end else begin
            tv     <= {tv[MUL_LAT-1:0], gnt};
            tid[0] <= win;
            for (int i = 1; i < MUL_LAT; i++) tid[i] <= tid[i-1];
            if (tv[MUL_LAT-1]) rid <= tid[MUL_LAT-1];
            if (gnt) begin
                ma <= bus.req_a[int'(win)*LOGQ +: LOGQ];
                mb <= bus.req_b[int'(win)*LOGQ +: LOGQ];
            end
`ifdef INTMUL_RR_SCHED_PRIO0_EN
            if (gnt && win != '0) ptr <= win;
`else
            if (gnt) ptr <= win;
`endif
        end
    end
endmodule

// File: tb/tb_intmul_rr_sched.sv
// tb_intmul_rr_sched: directed checks of grants, tag latency, busy, en gating and reset of intmul_rr_sched.
module tb_intmul_rr_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [63:0]  opa [4];
    logic [63:0]  opb [4];
    logic [127:0] p0, p1;
    int hg [256];
    logic [127:0] hp [256];
    int t = 0;
    int n_chk = 0;
    int n_bad = 0;
    intmul_rr_sched_if #(.LOGQ(64), .NUM_REQ(4)) bus();
    intmul_rr_sched #(.LOGQ(64), .NUM_REQ(4), .MUL_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*64 +: 64] = opa[i];
            bus.req_b[i*64 +: 64] = opb[i];
        end
    end
    always_ff @(posedge clk) begin
        p0 <= {64'b0, bus.mul_a} * {64'b0, bus.mul_b};
        p1 <= p0;
    end
    assign bus.mul_c = p1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic clr();
        t = 0;
        foreach (hg[i]) hg[i] = -1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clr();
    endtask

    // e is the requester expected to be granted this cycle (-1: none)
    task automatic cyc(input int e);
        int r;
        #3;
        chk("ready", 128'(bus.req_ready), e < 0 ? 128'd0 : 128'(1) << e);
        hg[t+3] = e;
        hp[t+3] = e < 0 ? 128'd0 : {64'b0, opa[e]} * {64'b0, opb[e]};
        r = hg[t];
        chk("rsp_valid", 128'(bus.rsp_valid), 128'(r >= 0));
        if (r >= 0) begin
            chk("rsp_id", 128'(bus.rsp_id), 128'(r));
            chk("rsp_c", bus.rsp_c, hp[t]);
        end
        chk("busy", 128'(bus.busy), 128'(hg[t] >= 0 || hg[t+1] >= 0 || hg[t+2] >= 0));
        @(posedge clk); #1;
        t++;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
            opb[i] = 64'h10 + 64'(i);
        end
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_a", 128'(bus.mul_a), 128'd0);
        chk("rst_mul_b", 128'(bus.mul_b), 128'd0);
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("rst_rsp_id", 128'(bus.rsp_id), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_ready", 128'(bus.req_ready), 128'd0);
        rst = 1'b1;
        bus.en = 1'b1;
        // single op on requester 2
        opa[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        opb[2] = 64'd2;
        bus.req_valid = 4'b0100;
        cyc(2);
        bus.req_valid = '0;
        chk("single_mul_a", 128'(bus.mul_a), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("single_mul_b", 128'(bus.mul_b), 128'd2);
        cyc(-1);
        cyc(-1);
        #1 chk("single_c", bus.rsp_c, 128'h1_FFFF_FFFF_FFFF_FFFE);
        cyc(-1);
        cyc(-1);
        cyc(-1);
        // all four continuously valid
        opa[2] = 64'h0123_4567_89AB_CDEF * 64'd3;
        opb[2] = 64'h12;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) cyc(k % 4);
        bus.req_valid = '0;
        repeat (4) cyc(-1);
        // en low for cycles 3..5
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            bus.en = !(k >= 3 && k <= 5);
            cyc(k < 3 ? k : (k <= 5 ? -1 : (k - 3) % 4));
        end
        bus.req_valid = '0;
        repeat (4) cyc(-1);
        // reset with an op in flight
        do_reset();
        bus.req_valid = 4'b0010;
        cyc(1);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("midrst_mul_a", 128'(bus.mul_a), 128'd0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        clr();
        repeat (4) cyc(-1);
        bus.req_valid = 4'b1010;
        cyc(1);
        cyc(3);
        cyc(1);
        bus.req_valid = '0;
        repeat (4) cyc(-1);
        // req 3 every cycle, req 0 every other cycle, fresh operands each cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            opa[0] = 64'hDEAD_BEEF_0123_4567 + 64'(k);
            opb[0] = 64'h8000_0000_0000_0001 - 64'(k);
            opa[3] = 64'hFFFF_FFFF_0000_0001 + 64'(3 * k);
            opb[3] = 64'h1234 + 64'(k);
            bus.req_valid = (k % 2 == 0) ? 4'b1001 : 4'b1000;
            cyc(k % 2 == 0 ? 0 : 3);
        end
        bus.req_valid = '0;
        repeat (4) cyc(-1);
        // reqs 0 and 2 continuously valid, then req 2 alone
        do_reset();
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
`ifdef INTMUL_RR_SCHED_PRIO0_EN
            cyc(0);
`else
            cyc(k % 2 == 0 ? 0 : 2);
`endif
        end
        bus.req_valid = 4'b0100;
        repeat (3) cyc(2);
        bus.req_valid = '0;
        repeat (4) cyc(-1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
